// File: rtl/conv_pix_tx.sv
// Raster pixel transmitter: upstream valid/ready into a small FIFO, then a
// registered pixel stream with eol/eof marking and horizontal blanking.
package conv_pkg;
    typedef logic [7:0] pixel_t;
endpackage

module conv_pix_tx
    import conv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int MAX_W = 1024,
    parameter int MAX_H = 1024
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    in_vld_i,
    input  conv_pkg::pixel_t        in_dat_i,
    output logic                    in_rdy_o,
    input  logic [$clog2(MAX_W):0]  cfg_width_i,
    input  logic [$clog2(MAX_H):0]  cfg_height_i,
    input  logic [3:0]              cfg_hblank_i,
    output logic                    pixel_vld_o,
    output conv_pkg::pixel_t        pixel_dat_o,
    output logic                    pixel_eol_o,
    output logic                    pixel_eof_o,
    input  logic                    stall_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_W);
    localparam int RW = $clog2(MAX_H);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HBLANK} state_t;

    pixel_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            in_rdy_q, in_rdy_d;
    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [3:0]      blank_q, blank_d;
    logic [CW-1:0]   w_last_q, w_last_d;
    logic [RW-1:0]   h_last_q, h_last_d;
    logic [3:0]      hb_q, hb_d;
    logic            vld_q, vld_d;
    logic            eol_q, eol_d;
    logic            eof_q, eof_d;
    pixel_t          dat_q, dat_d;

    logic push, emit, is_eol, is_eof;

    always_comb begin
        push   = in_vld_i & in_rdy_q;
        emit   = (state_q == RUN) && (count_q != '0) && !stall_i;
        is_eol = (col_q == w_last_q);
        is_eof = is_eol && (row_q == h_last_q);

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = emit ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !emit)
            count_d = count_q + 1'b1;
        else if (!push && emit)
            count_d = count_q - 1'b1;
        // Ready looks only at the next occupancy, never at a future pop
        in_rdy_d = (count_d < FULL);

        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        blank_d  = blank_q;
        w_last_d = w_last_q;
        h_last_d = h_last_q;
        hb_d     = hb_q;

        unique case (state_q)
            IDLE: begin
                w_last_d = (cfg_width_i == '0) ? '0 : CW'(cfg_width_i - 1'b1);
                h_last_d = (cfg_height_i == '0) ? '0 : RW'(cfg_height_i - 1'b1);
                hb_d     = cfg_hblank_i;
                col_d    = '0;
                row_d    = '0;
                if (count_q != '0)
                    state_d = RUN;
            end
            RUN: begin
                if (emit) begin
                    if (is_eol) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                        if (is_eof) begin
                            state_d = IDLE;
                        end else if (hb_q != '0) begin
                            state_d = HBLANK;
                            blank_d = hb_q;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            HBLANK: begin
                if (!stall_i) begin
                    blank_d = blank_q - 1'b1;
                    if (blank_q == 4'd1)
                        state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        vld_d = emit;
        eol_d = emit & is_eol;
        eof_d = emit & is_eof;
        dat_d = emit ? mem_q[rd_ptr_q] : dat_q;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= in_dat_i;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            in_rdy_q <= 1'b0;
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            blank_q  <= '0;
            w_last_q <= '0;
            h_last_q <= '0;
            hb_q     <= '0;
            vld_q    <= 1'b0;
            eol_q    <= 1'b0;
            eof_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            in_rdy_q <= in_rdy_d;
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            blank_q  <= blank_d;
            w_last_q <= w_last_d;
            h_last_q <= h_last_d;
            hb_q     <= hb_d;
            vld_q    <= vld_d;
            eol_q    <= eol_d;
            eof_q    <= eof_d;
            dat_q    <= dat_d;
        end
    end

    assign in_rdy_o    = in_rdy_q;
    assign pixel_vld_o = vld_q;
    assign pixel_eol_o = eol_q;
    assign pixel_eof_o = eof_q;
    assign pixel_dat_o = dat_q;
endmodule

// File: tb/tb_conv_pix_tx.sv
// Bench for conv_pix_tx: scenario tasks checked against a frame-level
// model of the pixel stream (position -> eol/eof, cycle gaps).
module tb_conv_pix_tx;
    import conv_pkg::*;

    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic        in_vld_i = 1'b0;
    pixel_t      in_dat_i = '0;
    logic        in_rdy_o;
    logic [10:0] cfg_width_i = 11'd4;
    logic [10:0] cfg_height_i = 11'd2;
    logic [3:0]  cfg_hblank_i = 4'd0;
    logic        pixel_vld_o;
    pixel_t      pixel_dat_o;
    logic        pixel_eol_o;
    logic        pixel_eof_o;
    logic        stall_i = 1'b0;

    conv_pix_tx #(.DEPTH(4), .MAX_W(1024), .MAX_H(1024)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .in_vld_i     (in_vld_i),
        .in_dat_i     (in_dat_i),
        .in_rdy_o     (in_rdy_o),
        .cfg_width_i  (cfg_width_i),
        .cfg_height_i (cfg_height_i),
        .cfg_hblank_i (cfg_hblank_i),
        .pixel_vld_o  (pixel_vld_o),
        .pixel_dat_o  (pixel_dat_o),
        .pixel_eol_o  (pixel_eol_o),
        .pixel_eof_o  (pixel_eof_o),
        .stall_i      (stall_i)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     first_push = 0;
    logic   st_s;
    pixel_t px [64];
    pixel_t q_dat [$];
    logic   q_eol [$];
    logic   q_eof [$];
    int     q_cyc [$];

    // Output monitor: collects emitted pixels with their edge number and
    // enforces that a stall sampled at an edge suppresses the next valid.
    always begin
        @(posedge clk);
        cyc++;
        st_s = stall_i;
        #1;
        if (st_s === 1'b1 && arst_n) begin
            checks++;
            if (pixel_vld_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_bubble cyc %0d vld %b want 0", cyc, pixel_vld_o);
            end
        end
        if (pixel_vld_o === 1'b1) begin
            q_dat.push_back(pixel_dat_o);
            q_eol.push_back(pixel_eol_o);
            q_eof.push_back(pixel_eof_o);
            q_cyc.push_back(cyc);
        end
    end

    function automatic bit m_eol(int i, int w, int h);
        return (i % w) == (w - 1);
    endfunction

    function automatic bit m_eof(int i, int w, int h);
        return m_eol(i, w, h) && (((i / w) % h) == (h - 1));
    endfunction

    task automatic clear_q();
        q_dat.delete();
        q_eol.delete();
        q_eof.delete();
        q_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0;
        in_vld_i = 1'b0;
        stall_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear_q();
        arst_n = 1'b1;
    endtask

    task automatic push_list(input int s, input int n, input bit gaps, output bit ok);
        int i = 0;
        int g = 0;
        while (i < n && g < 1000) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_vld_i = 1'b0;
            end else begin
                in_vld_i = 1'b1;
                in_dat_i = px[s+i];
                if (in_rdy_o === 1'b1) begin
                    if (i == 0) first_push = cyc + 1;
                    i++;
                end
            end
            @(negedge clk);
            g++;
        end
        in_vld_i = 1'b0;
        ok = (i == n);
    endtask

    task automatic wait_out(input int n, output bit ok);
        int g = 0;
        while (q_dat.size() < n && g < 500) begin
            @(negedge clk);
            g++;
        end
        ok = (q_dat.size() >= n);
    endtask

    task automatic test_reset();
        @(negedge clk);
        arst_n = 1'b0;
        #2;
        checks++;
        if (pixel_vld_o !== 1'b0 || pixel_eol_o !== 1'b0 || pixel_eof_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got %b%b%b want 000", pixel_vld_o, pixel_eol_o, pixel_eof_o);
        end
        checks++;
        if (pixel_dat_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_dat got %h want 00", pixel_dat_o);
        end
        checks++;
        if (in_rdy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy got %b want 0", in_rdy_o);
        end
        @(negedge clk);
        arst_n = 1'b1;
        checks++;
        if (in_rdy_o !== 1'b0) begin
            errors++;
            $display("FAIL rdy_before_edge got %b want 0", in_rdy_o);
        end
        @(negedge clk);
        checks++;
        if (in_rdy_o !== 1'b1) begin
            errors++;
            $display("FAIL rdy_after_edge got %b want 1", in_rdy_o);
        end
    endtask

    task automatic test_basic();
        bit ok, ok2;
        cfg_width_i = 11'd4; cfg_height_i = 11'd2; cfg_hblank_i = 4'd0;
        do_reset();
        for (int i = 0; i < 8; i++) px[i] = pixel_t'(i + 1);
        push_list(0, 8, 1'b0, ok);
        wait_out(8, ok2);
        checks++;
        if (!(ok && ok2)) begin
            errors++;
            $display("FAIL basic_timeout got %0d want 8", q_dat.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (q_dat[i] !== px[i] || q_eol[i] !== m_eol(i, 4, 2) || q_eof[i] !== m_eof(i, 4, 2)) begin
                    errors++;
                    $display("FAIL basic_pix[%0d] got %h/%b/%b want %h/%b/%b", i, q_dat[i],
                             q_eol[i], q_eof[i], px[i], m_eol(i, 4, 2), m_eof(i, 4, 2));
                end
            end
            checks++;
            if (q_cyc[0] !== first_push + 2) begin
                errors++;
                $display("FAIL basic_latency got %0d want %0d", q_cyc[0], first_push + 2);
            end
            checks++;
            if (q_cyc[7] !== first_push + 9) begin
                errors++;
                $display("FAIL basic_last got %0d want %0d", q_cyc[7], first_push + 9);
            end
        end
    endtask

    task automatic test_hblank();
        bit ok, ok2;
        cfg_width_i = 11'd4; cfg_height_i = 11'd2; cfg_hblank_i = 4'd3;
        do_reset();
        for (int i = 0; i < 8; i++) px[i] = pixel_t'($urandom);
        push_list(0, 8, 1'b0, ok);
        wait_out(8, ok2);
        checks++;
        if (!(ok && ok2)) begin
            errors++;
            $display("FAIL hblank_timeout got %0d want 8", q_dat.size());
        end else begin
            checks++;
            if (q_cyc[4] - q_cyc[3] !== 4) begin
                errors++;
                $display("FAIL hblank_gap got %0d want 4", q_cyc[4] - q_cyc[3]);
            end
            checks++;
            if (q_cyc[3] - q_cyc[0] !== 3) begin
                errors++;
                $display("FAIL hblank_line0 got %0d want 3", q_cyc[3] - q_cyc[0]);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (q_dat[i] !== px[i] || q_eol[i] !== m_eol(i, 4, 2) || q_eof[i] !== m_eof(i, 4, 2)) begin
                    errors++;
                    $display("FAIL hblank_pix[%0d] got %h/%b/%b want %h/%b/%b", i, q_dat[i],
                             q_eol[i], q_eof[i], px[i], m_eol(i, 4, 2), m_eof(i, 4, 2));
                end
            end
        end
    endtask

    task automatic test_stall();
        bit ok, ok2;
        cfg_width_i = 11'd4; cfg_height_i = 11'd2; cfg_hblank_i = 4'd0;
        do_reset();
        for (int i = 0; i < 8; i++) px[i] = pixel_t'($urandom);
        fork
            push_list(0, 8, 1'b0, ok);
            begin
                int g = 0;
                while (q_dat.size() < 2 && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                stall_i = 1'b1;
                @(negedge clk);
                @(negedge clk);
                stall_i = 1'b0;
            end
        join
        wait_out(8, ok2);
        checks++;
        if (!(ok && ok2)) begin
            errors++;
            $display("FAIL stall_timeout got %0d want 8", q_dat.size());
        end else begin
            checks++;
            if (q_cyc[2] - q_cyc[1] !== 3) begin
                errors++;
                $display("FAIL stall_bubbles got gap %0d want 3", q_cyc[2] - q_cyc[1]);
            end
            checks++;
            if (q_cyc[7] - q_cyc[0] !== 9) begin
                errors++;
                $display("FAIL stall_span got %0d want 9", q_cyc[7] - q_cyc[0]);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (q_dat[i] !== px[i] || q_eol[i] !== m_eol(i, 4, 2)) begin
                    errors++;
                    $display("FAIL stall_pix[%0d] got %h/%b want %h/%b", i, q_dat[i], q_eol[i],
                             px[i], m_eol(i, 4, 2));
                end
            end
        end
    endtask

    task automatic test_full();
        bit ok, ok2, ok3;
        cfg_width_i = 11'd4; cfg_height_i = 11'd2; cfg_hblank_i = 4'd0;
        do_reset();
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) px[i] = pixel_t'($urandom);
        push_list(0, 4, 1'b0, ok);
        checks++;
        if (!ok || in_rdy_o !== 1'b0) begin
            errors++;
            $display("FAIL full_rdy got %b want 0 (pushed ok %0d)", in_rdy_o, ok);
        end
        in_vld_i = 1'b1;
        in_dat_i = px[4];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (in_rdy_o !== 1'b0 || q_dat.size() != 0) begin
                errors++;
                $display("FAIL full_hold[%0d] got rdy %b out %0d want 0/0", k, in_rdy_o, q_dat.size());
            end
        end
        stall_i = 1'b0;
        push_list(4, 1, 1'b0, ok2);
        wait_out(5, ok3);
        checks++;
        if (!(ok2 && ok3)) begin
            errors++;
            $display("FAIL full_timeout got %0d want 5", q_dat.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (q_dat[i] !== px[i] || q_eol[i] !== m_eol(i, 4, 2)) begin
                    errors++;
                    $display("FAIL full_pix[%0d] got %h/%b want %h/%b", i, q_dat[i], q_eol[i],
                             px[i], m_eol(i, 4, 2));
                end
            end
        end
    endtask

    task automatic test_cfg_change();
        bit ok, ok2, ok3, ok4;
        int w, c;
        bit e;
        cfg_width_i = 11'd4; cfg_height_i = 11'd1; cfg_hblank_i = 4'd0;
        do_reset();
        for (int i = 0; i < 10; i++) px[i] = pixel_t'($urandom);
        push_list(0, 2, 1'b0, ok);
        wait_out(2, ok2);
        cfg_width_i = 11'd2;
        push_list(2, 8, 1'b0, ok3);
        wait_out(10, ok4);
        checks++;
        if (!(ok && ok2 && ok3 && ok4)) begin
            errors++;
            $display("FAIL cfg_timeout got %0d want 10", q_dat.size());
        end else begin
            w = 4;
            c = 0;
            for (int i = 0; i < 10; i++) begin
                e = (c == w - 1);
                checks++;
                if (q_dat[i] !== px[i] || q_eol[i] !== e || q_eof[i] !== e) begin
                    errors++;
                    $display("FAIL cfg_pix[%0d] got %h/%b/%b want %h/%b/%b", i, q_dat[i],
                             q_eol[i], q_eof[i], px[i], e, e);
                end
                if (e) begin
                    c = 0;
                    w = 2;
                end else begin
                    c++;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok, ok2, ok3;
        cfg_width_i = 11'd4; cfg_height_i = 11'd2; cfg_hblank_i = 4'd0;
        do_reset();
        for (int i = 0; i < 7; i++) px[i] = pixel_t'($urandom_range(1, 255));
        push_list(0, 3, 1'b0, ok);
        wait_out(2, ok2);
        arst_n = 1'b0;
        #1;
        checks++;
        if (pixel_vld_o !== 1'b0 || pixel_eol_o !== 1'b0 || pixel_eof_o !== 1'b0 ||
            pixel_dat_o !== 8'h00 || in_rdy_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outs got %b%b%b %h rdy %b want 000 00 rdy 0", pixel_vld_o,
                     pixel_eol_o, pixel_eof_o, pixel_dat_o, in_rdy_o);
        end
        @(negedge clk);
        arst_n = 1'b1;
        clear_q();
        repeat (4) @(negedge clk);
        checks++;
        if (q_dat.size() != 0) begin
            errors++;
            $display("FAIL midrst_fifo_empty got %0d outputs want 0", q_dat.size());
        end
        push_list(3, 4, 1'b0, ok3);
        wait_out(4, ok3);
        repeat (4) @(negedge clk);
        checks++;
        if (!(ok && ok2 && ok3) || q_dat.size() != 4) begin
            errors++;
            $display("FAIL midrst_count got %0d want 4", q_dat.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q_dat[i] !== px[3+i] || q_eol[i] !== m_eol(i, 4, 2) || q_eof[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL midrst_pix[%0d] got %h/%b/%b want %h/%b/0", i, q_dat[i],
                             q_eol[i], q_eof[i], px[3+i], m_eol(i, 4, 2));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            int w, h, hb, we, he, n, need;
            bit ok, ok2, done;
            w  = $urandom_range(0, 6);
            h  = $urandom_range(0, 3);
            hb = $urandom_range(0, 3);
            cfg_width_i  = 11'(w);
            cfg_height_i = 11'(h);
            cfg_hblank_i = 4'(hb);
            do_reset();
            we = (w == 0) ? 1 : w;
            he = (h == 0) ? 1 : h;
            n  = we * he * 2;
            for (int i = 0; i < n; i++) px[i] = pixel_t'($urandom);
            done = 1'b0;
            fork
                begin
                    push_list(0, n, 1'b1, ok);
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        stall_i = ($urandom_range(0, 3) == 0);
                        @(negedge clk);
                    end
                    stall_i = 1'b0;
                end
            join
            wait_out(n, ok2);
            checks++;
            if (!(ok && ok2)) begin
                errors++;
                $display("FAIL rnd%0d_timeout got %0d want %0d", it, q_dat.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (q_dat[i] !== px[i] || q_eol[i] !== m_eol(i, we, he) ||
                        q_eof[i] !== m_eof(i, we, he)) begin
                        errors++;
                        $display("FAIL rnd%0d_pix[%0d] w%0d h%0d got %h/%b/%b want %h/%b/%b",
                                 it, i, we, he, q_dat[i], q_eol[i], q_eof[i], px[i],
                                 m_eol(i, we, he), m_eof(i, we, he));
                    end
                    if (i < n - 1 && m_eol(i, we, he)) begin
                        need = m_eof(i, we, he) ? 2 : hb + 1;
                        checks++;
                        if (q_cyc[i+1] - q_cyc[i] < need) begin
                            errors++;
                            $display("FAIL rnd%0d_gap[%0d] got %0d want >=%0d", it, i,
                                     q_cyc[i+1] - q_cyc[i], need);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_hblank();
        test_stall();
        test_full();
        test_cfg_change();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
